flappy_core: RTL and testbench

- Parametrised game engine for the LED-matrix Flappy Bird, a successor to the fixed 8x8 action block.
- Owns bird position, scrolling beam field, a free-running LFSR gap generator, collision detection, score and difficulty ramp.
- Advances one game step per display tick (e_act_i) and hands a flattened frame plus a ready pulse to the display driver.

---
 rtl/flappy_core.sv | 183 ++++++++++++++++++
 tb/tb_flappy_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_core.sv
`default_nettype none
// flappy_core: LED-matrix Flappy Bird engine. Owns the bird, the scrolling beam field, the LFSR gap source,
// collision, the saturating score and the scroll-speed ramp. It advances one game step per e_act_i tick.
module flappy_core #(
  parameter int         GW           = 8,
  parameter int         GH           = 8,
  parameter int         GAP          = 2,
  parameter int         SHIFT_DIV    = 16,
  parameter int         MIN_DIV      = 4,
  parameter int         SPEEDUP_PTS  = 4,
  parameter int         BEAM_SPACING = 4,
  parameter int         SCORE_W      = 8,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 up_i,
  input  logic                 down_i,
  input  logic                 e_act_i,
  output logic [GW*GH-1:0]     matrix_o,
  output logic                 d_act_o,
  output logic                 dead_o,
  output logic [SCORE_W-1:0]   score_o,
  output logic [1:0]           state_o
);

  localparam int N      = GW * GH;
  localparam int YW     = (GH > 1) ? $clog2(GH) : 1;
  localparam int CW     = $clog2(SHIFT_DIV) + 1;
  localparam int SPW    = (BEAM_SPACING > 1) ? $clog2(BEAM_SPACING) : 1;
  localparam int PW     = (SPEEDUP_PTS > 1) ? $clog2(SPEEDUP_PTS) : 1;
  localparam int DIAG_N = (GW < GH) ? GW : GH;

  localparam logic [YW-1:0]  Y_TOP       = YW'(GH - 1);
  localparam logic [YW-1:0]  Y_START     = YW'(GH / 2);
  localparam logic [CW-1:0]  PERIOD_INIT = CW'(SHIFT_DIV);
  localparam logic [CW-1:0]  PERIOD_MIN  = CW'(MIN_DIV);
  localparam logic [SPW-1:0] SPACE_LAST  = SPW'(BEAM_SPACING - 1);
  localparam logic [PW-1:0]  PTS_LAST    = PW'(SPEEDUP_PTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10
  } state_t;

  state_t           state;
  logic [7:0]       lfsr;
  logic [YW-1:0]    bird_y;
  logic [N-1:0]     field;
  logic [CW-1:0]    scroll_cnt;
  logic [CW-1:0]    period;
  logic [SPW-1:0]   space_cnt;
  logic [PW-1:0]    pts_cnt;
  logic             released;

  logic             lfsr_fb;
  logic [GH-1:0]    beam_col;
  logic [GH-1:0]    new_col0;
  logic [N-1:0]     diag_frame;
  logic [N-1:0]     start_frame;
  logic [N-1:0]     bird_old;
  logic [N-1:0]     bird_new;
  logic [N-1:0]     shifted;
  logic [N-1:0]     new_field;
  logic             up_only;
  logic             down_only;
  logic             edge_death;
  logic             scroll;
  logic             hit;
  logic             passed;
  logic             score_inc;
  logic             speedup;
  logic             start;
  logic [YW-1:0]    new_y;
  logic [CW-1:0]    new_period;
  int               gap_lo;

  assign lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign start_frame = {{(N-1){1'b0}}, 1'b1} << Y_START;
  assign state_o     = state;
  assign start       = e_act_i && up_i && ((state == IDLE) || ((state == DEAD) && released));

  // Gap draw folds out-of-range rows back into the valid range.
  always_comb begin
    gap_lo = int'(lfsr[YW-1:0]);
    if (gap_lo > GH - GAP) gap_lo = gap_lo - (GH - GAP + 1);
    beam_col = '0;
    for (int y = 0; y < GH; y++) beam_col[y] = !((y >= gap_lo) && (y < gap_lo + GAP));
  end

  always_comb begin
    diag_frame = '0;
    for (int x = 0; x < DIAG_N; x++) diag_frame[x*GH + x] = 1'b1;
  end

  // One RUN step: move, scroll, then collision against the new column 0.
  always_comb begin
    up_only    = up_i & ~down_i;
    down_only  = down_i & ~up_i;
    edge_death = (up_only && (bird_y == Y_TOP)) || (down_only && (bird_y == '0));
    new_y      = bird_y;
    if (up_only && !edge_death)        new_y = bird_y + 1'b1;
    else if (down_only && !edge_death) new_y = bird_y - 1'b1;

    scroll     = (scroll_cnt == period - 1'b1);
    shifted    = {((space_cnt == '0) ? beam_col : {GH{1'b0}}), field[N-1:GH]};
    new_field  = scroll ? shifted : field;
    new_col0   = new_field[GH-1:0];
    hit        = new_col0[new_y];
    passed     = !hit && (|new_col0) && (new_col0 != field[GH-1:0]);
    score_inc  = passed && (score_o != '1);
    speedup    = score_inc && (pts_cnt == PTS_LAST);
    new_period = (speedup && (period > PERIOD_MIN)) ? period - 1'b1 : period;
    bird_old   = {{(N-1){1'b0}}, 1'b1} << bird_y;
    bird_new   = {{(N-1){1'b0}}, 1'b1} << new_y;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      bird_y     <= '0;
      field      <= '0;
      scroll_cnt <= '0;
      period     <= PERIOD_INIT;
      space_cnt  <= '0;
      pts_cnt    <= '0;
      released   <= 1'b0;
      matrix_o   <= '0;
      d_act_o    <= 1'b0;
      dead_o     <= 1'b0;
      score_o    <= '0;
    end else begin
      lfsr    <= {lfsr[6:0], lfsr_fb};
      d_act_o <= e_act_i;
      if (start) begin
        state      <= RUN;
        bird_y     <= Y_START;
        field      <= '0;
        scroll_cnt <= '0;
        period     <= PERIOD_INIT;
        space_cnt  <= '0;
        pts_cnt    <= '0;
        score_o    <= '0;
        released   <= 1'b0;
        dead_o     <= 1'b0;
        matrix_o   <= start_frame;
      end else if (e_act_i) begin
        case (state)
          IDLE: matrix_o <= diag_frame;
          RUN: begin
            if (edge_death) begin
              state    <= DEAD;
              dead_o   <= 1'b1;
              released <= 1'b0;
              matrix_o <= field | bird_old;
            end else begin
              bird_y     <= new_y;
              field      <= new_field;
              matrix_o   <= new_field | bird_new;
              scroll_cnt <= scroll ? '0 : scroll_cnt + 1'b1;
              if (scroll) space_cnt <= (space_cnt == SPACE_LAST) ? '0 : space_cnt + 1'b1;
              if (hit) begin
                state    <= DEAD;
                dead_o   <= 1'b1;
                released <= 1'b0;
              end else if (score_inc) begin
                score_o <= score_o + 1'b1;
                pts_cnt <= speedup ? '0 : pts_cnt + 1'b1;
                period  <= new_period;
              end
            end
          end
          DEAD: if (!up_i) released <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flappy_core.sv
`default_nettype none
// Directed bench for flappy_core: idle frame, edge death, gap steering, speed ramp,
// restart handshake and mid-game reset.
module tb_flappy_core;

  localparam int GW = 8, GH = 8, GAP = 2, SHIFT_DIV = 4, MIN_DIV = 2, SPEEDUP_PTS = 2, BEAM_SPACING = 4;
  localparam logic [63:0] DIAG = 64'h8040201008040201;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1, up_i = 1'b0, down_i = 1'b0, e_act_i = 1'b0;
  logic [63:0] matrix_o;
  logic        d_act_o, dead_o;
  logic [7:0]  score_o;
  logic [1:0]  state_o;

  flappy_core #(
    .GW(GW), .GH(GH), .GAP(GAP), .SHIFT_DIV(SHIFT_DIV), .MIN_DIV(MIN_DIV),
    .SPEEDUP_PTS(SPEEDUP_PTS), .BEAM_SPACING(BEAM_SPACING), .SCORE_W(8), .LFSR_SEED(8'hA5)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .up_i(up_i), .down_i(down_i), .e_act_i(e_act_i),
    .matrix_o(matrix_o), .d_act_o(d_act_o), .dead_o(dead_o), .score_o(score_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int         checks = 0, errors = 0;
  logic [7:0] lfsr_m = 8'h00, tick_lfsr = 8'h00;
  int         m_y, m_cnt, m_period, m_space, m_score;
  int         m_col [GW];

  // Reference LFSR: x^8+x^6+x^5+x^4+1, advancing every clock.
  always @(posedge clk) begin
    if (reset_i) lfsr_m <= 8'hA5;
    else         lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1; e_act_i = 1'b0; up_i = 1'b0; down_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic tick(input logic u, input logic d);
    @(negedge clk);
    up_i = u; down_i = d; e_act_i = 1'b1;
    tick_lfsr = lfsr_m;
    @(negedge clk);
    e_act_i = 1'b0; up_i = 1'b0; down_i = 1'b0;
  endtask

  function automatic int gap_of(input logic [7:0] v);
    int r;
    r = int'(v[2:0]);
    if (r > GH - GAP) r = r - (GH - GAP + 1);
    return r;
  endfunction

  function automatic logic [7:0] beam_mask(input int g);
    logic [7:0] m;
    m = 8'hFF;
    for (int y = 0; y < GH; y++) if (y >= g && y < g + GAP) m[y] = 1'b0;
    return m;
  endfunction

  task automatic model_init();
    m_y = GH / 2; m_cnt = 0; m_period = SHIFT_DIV; m_space = 0; m_score = 0;
    for (int x = 0; x < GW; x++) m_col[x] = -1;
  endtask

  // Game-level model: columns hold the gap row of a beam, or -1 when empty.
  task automatic model_step(input logic u, input logic d);
    bit uo, dn, scrolled;
    uo = u && !d; dn = d && !u; scrolled = 0;
    if ((uo && m_y == GH - 1) || (dn && m_y == 0)) return;
    m_y = m_y + (uo ? 1 : 0) - (dn ? 1 : 0);
    if (m_cnt == m_period - 1) begin
      m_cnt = 0;
      for (int x = 0; x < GW - 1; x++) m_col[x] = m_col[x+1];
      m_col[GW-1] = (m_space == 0) ? gap_of(tick_lfsr) : -1;
      m_space = (m_space + 1) % BEAM_SPACING;
      scrolled = 1;
    end else begin
      m_cnt++;
    end
    if (scrolled && m_col[0] >= 0 && m_y >= m_col[0] && m_y < m_col[0] + GAP) begin
      m_score++;
      if (m_score % SPEEDUP_PTS == 0 && m_period > MIN_DIV) m_period--;
    end
  endtask

  task automatic steer(input bit outside, output logic u, output logic d);
    int tgt;
    tgt = -1;
    for (int x = GW - 1; x >= 0; x--) if (m_col[x] >= 0) tgt = m_col[x];
    if (tgt >= 0 && outside) tgt = (tgt + GAP <= GH - 1) ? tgt + GAP : tgt - 1;
    u = (tgt >= 0) && (m_y < tgt);
    d = (tgt >= 0) && (m_y > tgt);
  endtask

  initial begin
    logic        u, d;
    int          last_scroll, exp_iv;
    logic [55:0] prev_cols;
    logic [7:0]  prev_score;
    bit          done6;

    do_reset();
    check("rst_matrix", matrix_o, 64'h0);
    check("rst_state", state_o, 2'b00);
    check("rst_dead", dead_o, 1'b0);
    check("rst_score", score_o, 8'd0);
    check("rst_dact", d_act_o, 1'b0);

    tick(1'b0, 1'b0);
    check("idle_diag", matrix_o, DIAG);
    check("idle_state", state_o, 2'b00);
    check("dact_pulse", d_act_o, 1'b1);
    @(negedge clk);
    check("dact_after", d_act_o, 1'b0);

    tick(1'b1, 1'b0);
    check("start_state", state_o, 2'b01);
    check("start_frame", matrix_o, 64'h10);
    check("start_score", score_o, 8'd0);
    check("start_dead", dead_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      check("climb", matrix_o, 64'h20 << i);
    end
    tick(1'b1, 1'b0);
    check("ceil_dead", dead_o, 1'b1);
    check("ceil_state", state_o, 2'b10);
    check("ceil_frame", matrix_o, 64'h80);

    // Steer away from the first gap: collision when the beam reaches column 0.
    do_reset();
    tick(1'b1, 1'b0);
    model_init();
    for (int t = 1; t <= 32; t++) begin
      steer(1'b1, u, d);
      tick(u, d);
      model_step(u, d);
      if (t == 31) check("out_alive31", dead_o, 1'b0);
    end
    check("out_dead32", dead_o, 1'b1);
    check("out_state32", state_o, 2'b10);

    // Steer through the gaps.
    do_reset();
    tick(1'b1, 1'b0);
    model_init();
    for (int t = 1; t <= 32; t++) begin
      if (t == 1) begin u = 1'b1; d = 1'b1; end
      else steer(1'b0, u, d);
      tick(u, d);
      model_step(u, d);
      if (t == 1)  check("both_hold", matrix_o, 64'h10);
      if (t == 3)  check("no_scroll3", matrix_o[63:8], 56'h0);
      if (t == 4)  check("beam_enter", matrix_o[63:56], beam_mask(m_col[GW-1]));
      if (t == 31) check("pass_alive31", dead_o, 1'b0);
    end
    check("pass_score", score_o, 8'd1);
    check("pass_dead", dead_o, 1'b0);
    check("pass_col0", matrix_o[7:0], beam_mask(m_col[0]) | (8'h01 << m_y));

    prev_cols = matrix_o[63:8]; prev_score = score_o; last_scroll = 32; exp_iv = 0; done6 = 0;
    for (int t = 33; t < 250 && !done6 && !dead_o; t++) begin
      steer(1'b0, u, d);
      tick(u, d);
      model_step(u, d);
      if (matrix_o[63:8] != prev_cols) begin
        if (exp_iv != 0) begin
          check("scroll_iv", t - last_scroll, exp_iv);
          if (score_o >= 8'd6) done6 = 1;
          exp_iv = 0;
        end
        if (score_o != prev_score) begin
          if (score_o == 8'd2) exp_iv = 3;
          else if (score_o == 8'd4 || score_o == 8'd6) exp_iv = 2;
        end
        last_scroll = t; prev_cols = matrix_o[63:8]; prev_score = score_o;
      end
    end
    check("score6", score_o, 8'd6);
    check("alive_s6", dead_o, 1'b0);

    for (int i = 0; i < 10 && !dead_o; i++) tick(1'b1, 1'b0);
    check("die_dead", dead_o, 1'b1);
    check("die_state", state_o, 2'b10);
    tick(1'b1, 1'b0);
    check("hold_up1", state_o, 2'b10);
    tick(1'b1, 1'b0);
    check("hold_up2", state_o, 2'b10);
    tick(1'b0, 1'b0);
    check("release", state_o, 2'b10);
    tick(1'b1, 1'b0);
    check("restart_state", state_o, 2'b01);
    check("restart_score", score_o, 8'd0);
    check("restart_dead", dead_o, 1'b0);
    check("restart_frame", matrix_o, 64'h10);

    tick(1'b0, 1'b0);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("mid_rst_state", state_o, 2'b00);
    check("mid_rst_matrix", matrix_o, 64'h0);
    check("mid_rst_score", score_o, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
